// File: rtl/sm_output_if.sv
// -----------------------------------------------------------------------------
// sm_output_if
// Bundles the CPU-side write port and the router local-port handshake of the
// schoolMIPS network transmit path.
//   cpuData/cpuDest/cpuWrite : word, destination and write strobe from the CPU
//   cpuBusy/overflow         : FIFO full and sticky dropped-write flag
//   dataOutL/Inr_L/Inw_L     : flit, request and acknowledge to/from the router
//   txDone/selfDest          : delivery pulse and local-destination flag
// Modport slave is the transmitter itself; modport master is its environment
// (CPU plus router).
// -----------------------------------------------------------------------------
interface sm_output_if #(
    parameter int DATA_WIDTH_EX = 37
);
    logic [31:0]              cpuData;
    logic [3:0]               cpuDest;
    logic                     cpuWrite;
    logic                     cpuBusy;
    logic                     overflow;
    logic [DATA_WIDTH_EX-1:0] dataOutL;
    logic                     Inr_L;
    logic                     Inw_L;
    logic                     txDone;
    logic                     selfDest;

    modport slave (
        input  cpuData, cpuDest, cpuWrite, Inw_L,
        output cpuBusy, overflow, dataOutL, Inr_L, txDone, selfDest
    );

    modport master (
        output cpuData, cpuDest, cpuWrite, Inw_L,
        input  cpuBusy, overflow, dataOutL, Inr_L, txDone, selfDest
    );
endinterface

// File: rtl/sm_output.sv
// -----------------------------------------------------------------------------
// sm_output
// Transmit side of the schoolMIPS network interface. CPU words are packed into
// 37-bit flits {data, valid, destY, destX}, buffered in a small FIFO and handed
// to the router local input port with a four-phase request/acknowledge
// handshake (IDLE -> REQ -> RELEASE).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears FIFO, FSM and all outputs
//   bus   : sm_output_if.slave (CPU write port + router handshake)
// -----------------------------------------------------------------------------
module sm_output #(
    parameter logic [3:0] position      = 4'b0101,
    parameter int         DATA_WIDTH_EX = 37,
    parameter int         FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    sm_output_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e                   state_q,    state_d;
    logic [DATA_WIDTH_EX-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH_EX-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]         count_q,    count_d;
    logic                     overflow_q, overflow_d;
    logic [DATA_WIDTH_EX-1:0] data_out_q, data_out_d;
    logic                     inr_q,      inr_d;
    logic                     tx_done_q,  tx_done_d;
    logic                     self_dest_q, self_dest_d;

    logic                     full_s;
    logic                     wr_accept_s;
    logic                     pop_s;
    logic [DATA_WIDTH_EX-1:0] flit_s;
    logic [DATA_WIDTH_EX-1:0] head_s;

    assign full_s      = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_accept_s = bus.cpuWrite & ~full_s;
    assign flit_s      = {bus.cpuData, 1'b1, bus.cpuDest};
    assign head_s      = mem_q[rd_ptr_q];

    // FIFO storage, pointers, occupancy and sticky overflow next-state
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        // A write while full is lost even if the FSM pops in the same cycle.
        overflow_d = overflow_q | (bus.cpuWrite & full_s);

        if (wr_accept_s) begin
            mem_d[wr_ptr_q] = flit_s;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Handshake FSM: next state, head pop and registered output values
    always_comb begin
        state_d     = state_q;
        pop_s       = 1'b0;
        data_out_d  = data_out_q;
        inr_d       = inr_q;
        tx_done_d   = 1'b0;
        self_dest_d = self_dest_q;

        case (state_q)
            IDLE: begin
                if (count_q != CNT_W'(0)) begin
                    pop_s       = 1'b1;
                    data_out_d  = head_s;
                    self_dest_d = (head_s[3:0] == position);
                    inr_d       = 1'b1;
                    state_d     = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus.Inw_L) begin
                    inr_d     = 1'b0;
                    tx_done_d = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    state_d = REQ;
                end
            end
            RELEASE: begin
                inr_d = 1'b0;
                // Router must drop its acknowledge before the next request.
                if (!bus.Inw_L) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
                inr_d   = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            data_out_q  <= '0;
            inr_q       <= 1'b0;
            tx_done_q   <= 1'b0;
            self_dest_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            data_out_q  <= data_out_d;
            inr_q       <= inr_d;
            tx_done_q   <= tx_done_d;
            self_dest_q <= self_dest_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.cpuBusy  = full_s;
    assign bus.overflow = overflow_q;
    assign bus.dataOutL = data_out_q;
    assign bus.Inr_L    = inr_q;
    assign bus.txDone   = tx_done_q;
    assign bus.selfDest = self_dest_q;

endmodule

// File: tb/tb_sm_output.sv
module tb_sm_output;
    logic clk = 1'b0;
    logic reset;

    sm_output_if ifc ();

    sm_output #(
        .position      (4'b0101),
        .DATA_WIDTH_EX (37),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        auto_ack = 1'b0;
    logic        saw_req  = 1'b0;
    logic [36:0] rx_q [$];
    int          rx_cyc [$];

    function automatic logic [36:0] flit(input logic [31:0] d, input logic [3:0] dest);
        return {d, 1'b1, dest};
    endfunction

    // One clock: sample just after the rising edge, log deliveries, play router.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ifc.txDone === 1'b1) begin
            rx_q.push_back(ifc.dataOutL);
            rx_cyc.push_back(cyc);
        end
        if (ifc.Inr_L === 1'b1) saw_req = 1'b1;
        if (auto_ack) ifc.Inw_L = ifc.Inr_L;
    endtask

    task automatic do_write(input logic [31:0] d, input logic [3:0] dest);
        ifc.cpuData  = d;
        ifc.cpuDest  = dest;
        ifc.cpuWrite = 1'b1;
        tick();
        ifc.cpuWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        ifc.cpuData  = 32'h0;
        ifc.cpuDest  = 4'h0;
        ifc.cpuWrite = 1'b0;
        ifc.Inw_L    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({ifc.cpuBusy, ifc.overflow, ifc.Inr_L, ifc.txDone, ifc.selfDest, ifc.dataOutL} !== 42'd0) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: busy=%b ovf=%b req=%b done=%b self=%b data=%h, want all 0",
                         i, ifc.cpuBusy, ifc.overflow, ifc.Inr_L, ifc.txDone, ifc.selfDest, ifc.dataOutL);
            end
        end
        for (int i = 0; i < 8; i++) begin
            ifc.Inw_L = ~ifc.Inw_L;
            tick();
            total++;
            if ({ifc.Inr_L, ifc.txDone} !== 2'b00) begin
                bad++;
                $display("FAIL idle_ack_ignored cycle %0d: req=%b done=%b, want 0 0", i, ifc.Inr_L, ifc.txDone);
            end
        end
        ifc.Inw_L = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rx_q.delete();
        do_write(32'hDEADBEEF, 4'b1010);
        total++;
        if (ifc.Inr_L !== 1'b0) begin
            bad++;
            $display("FAIL single_no_req_at_E0: req=%b, want 0", ifc.Inr_L);
        end
        tick();
        total++;
        if ({ifc.Inr_L, ifc.selfDest, ifc.dataOutL} !== {1'b1, 1'b0, 37'h1BD5B7DDFA}) begin
            bad++;
            $display("FAIL single_request: req=%b self=%b data=%h, want 1 0 1bd5b7ddfa",
                     ifc.Inr_L, ifc.selfDest, ifc.dataOutL);
        end
        repeat (3) tick();
        total++;
        if ({ifc.Inr_L, ifc.txDone, ifc.dataOutL} !== {1'b1, 1'b0, 37'h1BD5B7DDFA}) begin
            bad++;
            $display("FAIL single_hold: req=%b done=%b data=%h, want 1 0 1bd5b7ddfa",
                     ifc.Inr_L, ifc.txDone, ifc.dataOutL);
        end
        ifc.Inw_L = 1'b1;
        tick();
        total++;
        if ({ifc.Inr_L, ifc.txDone} !== 2'b01) begin
            bad++;
            $display("FAIL single_ack: req=%b done=%b, want 0 1", ifc.Inr_L, ifc.txDone);
        end
        tick();
        total++;
        if ({ifc.Inr_L, ifc.txDone} !== 2'b00) begin
            bad++;
            $display("FAIL single_done_pulse: req=%b done=%b, want 0 0", ifc.Inr_L, ifc.txDone);
        end
        ifc.Inw_L = 1'b0;
        repeat (4) tick();
        total++;
        if (rx_q.size() != 1 || ifc.Inr_L !== 1'b0 || ifc.dataOutL !== 37'h1BD5B7DDFA) begin
            bad++;
            $display("FAIL single_once: delivered=%0d req=%b data=%h, want 1 0 1bd5b7ddfa",
                     rx_q.size(), ifc.Inr_L, ifc.dataOutL);
        end
    endtask

    task automatic test_fill_overflow();
        rx_q.delete();
        ifc.Inw_L = 1'b0;
        for (int i = 1; i <= 5; i++) do_write(32'(i), 4'b0011);
        total++;
        if ({ifc.cpuBusy, ifc.overflow, ifc.Inr_L, ifc.dataOutL} !== {1'b1, 1'b0, 1'b1, 37'h0000000033}) begin
            bad++;
            $display("FAIL fill_full: busy=%b ovf=%b req=%b data=%h, want 1 0 1 0000000033",
                     ifc.cpuBusy, ifc.overflow, ifc.Inr_L, ifc.dataOutL);
        end
        do_write(32'd6, 4'b0011);
        total++;
        if ({ifc.cpuBusy, ifc.overflow} !== 2'b11) begin
            bad++;
            $display("FAIL overflow_set: busy=%b ovf=%b, want 1 1", ifc.cpuBusy, ifc.overflow);
        end
        auto_ack = 1'b1;
        repeat (25) tick();
        auto_ack  = 1'b0;
        ifc.Inw_L = 1'b0;
        tick();
        total++;
        if (rx_q.size() != 5) begin
            bad++;
            $display("FAIL fill_count: delivered=%0d, want 5", rx_q.size());
        end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== flit(32'(i + 1), 4'b0011)) begin
                bad++;
                $display("FAIL fill_order[%0d]: got %h, want %h", i, rx_q[i], flit(32'(i + 1), 4'b0011));
            end
        end
        total++;
        if ({ifc.overflow, ifc.cpuBusy} !== 2'b10) begin
            bad++;
            $display("FAIL overflow_sticky: ovf=%b busy=%b, want 1 0", ifc.overflow, ifc.cpuBusy);
        end
    endtask

    task automatic test_back_to_back();
        rx_q.delete();
        rx_cyc.delete();
        auto_ack = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            total++;
            if (ifc.cpuBusy !== 1'b0) begin
                bad++;
                $display("FAIL b2b_accept_%0d: busy=%b, want 0", i, ifc.cpuBusy);
            end
            do_write(32'h100 + 32'(i), 4'b1001);
        end
        total++;
        if (ifc.cpuBusy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_full: busy=%b, want 1", ifc.cpuBusy);
        end
        repeat (30) tick();
        auto_ack  = 1'b0;
        ifc.Inw_L = 1'b0;
        tick();
        total++;
        if (rx_q.size() != 6) begin
            bad++;
            $display("FAIL b2b_count: delivered=%0d, want 6", rx_q.size());
        end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== flit(32'h100 + 32'(i + 1), 4'b1001)) begin
                bad++;
                $display("FAIL b2b_order[%0d]: got %h, want %h", i, rx_q[i], flit(32'h100 + 32'(i + 1), 4'b1001));
            end
        end
        for (int i = 1; i < rx_cyc.size(); i++) begin
            total++;
            if (rx_cyc[i] - rx_cyc[i-1] != 3) begin
                bad++;
                $display("FAIL b2b_rate[%0d]: gap=%0d cycles, want 3", i, rx_cyc[i] - rx_cyc[i-1]);
            end
        end
    endtask

    task automatic test_self_dest();
        rx_q.delete();
        ifc.Inw_L = 1'b0;
        do_write(32'h12345678, 4'b0101);
        tick();
        total++;
        if ({ifc.Inr_L, ifc.selfDest, ifc.dataOutL} !== {1'b1, 1'b1, 37'h02468ACF15}) begin
            bad++;
            $display("FAIL self_flag: req=%b self=%b data=%h, want 1 1 02468acf15",
                     ifc.Inr_L, ifc.selfDest, ifc.dataOutL);
        end
        auto_ack = 1'b1;
        repeat (6) tick();
        auto_ack  = 1'b0;
        ifc.Inw_L = 1'b0;
        tick();
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== 37'h02468ACF15 || ifc.selfDest !== 1'b1) begin
            bad++;
            $display("FAIL self_sent: delivered=%0d self=%b, want 1 flit 02468acf15 and self 1",
                     rx_q.size(), ifc.selfDest);
        end
    endtask

    task automatic test_reset_mid();
        rx_q.delete();
        ifc.Inw_L = 1'b0;
        do_write(32'hA1, 4'b0001);
        do_write(32'hA2, 4'b0010);
        do_write(32'hA3, 4'b0011);
        total++;
        if ({ifc.Inr_L, ifc.dataOutL} !== {1'b1, 37'h0000001431}) begin
            bad++;
            $display("FAIL mid_in_req: req=%b data=%h, want 1 0000001431", ifc.Inr_L, ifc.dataOutL);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({ifc.Inr_L, ifc.txDone, ifc.overflow, ifc.cpuBusy, ifc.selfDest, ifc.dataOutL} !== 42'd0) begin
            bad++;
            $display("FAIL mid_async_reset: req=%b done=%b ovf=%b busy=%b self=%b data=%h, want all 0",
                     ifc.Inr_L, ifc.txDone, ifc.overflow, ifc.cpuBusy, ifc.selfDest, ifc.dataOutL);
        end
        tick();
        reset    = 1'b0;
        saw_req  = 1'b0;
        auto_ack = 1'b1;
        repeat (15) tick();
        total++;
        if (saw_req !== 1'b0 || rx_q.size() != 0) begin
            bad++;
            $display("FAIL mid_fifo_empty: saw_req=%b delivered=%0d, want 0 0", saw_req, rx_q.size());
        end
        do_write(32'hB0B0CAFE, 4'b0110);
        repeat (8) tick();
        auto_ack  = 1'b0;
        ifc.Inw_L = 1'b0;
        tick();
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== flit(32'hB0B0CAFE, 4'b0110)) begin
            bad++;
            $display("FAIL mid_new_write: delivered=%0d, want exactly 1 flit %h",
                     rx_q.size(), flit(32'hB0B0CAFE, 4'b0110));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_self_dest();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm_output.md
# sm_output

Transmit side of the schoolMIPS network interface. Accepts 32-bit words and destination coordinates from the CPU core and buffers them in a small FIFO. Each word is packed into a 37-bit flit and delivered to the local (L) input port of the mesh router over a four-phase request/acknowledge handshake. It is the counterpart of the receive path that strips flits back to 32-bit words for the CPU.

## Interface
Parameters:
- position, 4'b0101, own node coordinates: Y in [3:2], X in [1:0]; drives the source-match flag.
- DATA_WIDTH_EX, 37, flit width; fixed layout {data[31:0], valid, destY[1:0], destX[1:0]}.
- FIFO_DEPTH, 4, CPU-side buffer entries; must be a power of two, at least 2.

Ports (reset is asynchronous, active-high; clock is clk):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cpuData  in  32  payload word from the CPU.
- cpuDest  in  4  destination coordinates, same encoding as position.
- cpuWrite  in  1  one-cycle write strobe; sampled with cpuData and cpuDest.
- cpuBusy  out  1  FIFO full; writes are ignored while high.
- overflow  out  1  sticky; set by a write attempted while full, cleared only by reset.
- dataOutL  out  37  flit to the router local input port.
- Inr_L  out  1  request; flit on dataOutL is valid.
- Inw_L  in  1  router acknowledge; synchronous to clk.
- txDone  out  1  one-cycle pulse when a flit is acknowledged.
- selfDest  out  1  high while the flit on dataOutL has dest == position (informational; the flit is still sent).

## Operation
- Flit packing: dataOutL = {cpuData, 1'b1, cpuDest}. Bit 4 is always 1 for a real flit. The router and receiver take the payload from [36:5] and the routing coordinates from [3:0].
- FIFO: FIFO_DEPTH entries, with read pointer, write pointer and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- A write is accepted when cpuWrite=1 and count<FIFO_DEPTH.
  - A write when full is dropped and sets overflow. This holds even if a pop happens in the same cycle.
- A simultaneous accepted write and pop leaves count unchanged.
- cpuBusy = (count == FIFO_DEPTH), combinational from the registered count.
- FSM states: IDLE, REQ, RELEASE.
  - IDLE: if count != 0, pop the head, load dataOutL, set Inr_L=1, go to REQ. Otherwise stay in IDLE.
  - REQ: hold Inr_L=1 and dataOutL stable. On Inw_L=1: Inr_L<=0, txDone<=1 for one cycle, go to RELEASE.
  - RELEASE: Inr_L=0. On Inw_L=0 go to IDLE. Otherwise stay in RELEASE, so the router must drop its acknowledge before the next request.
- dataOutL keeps the last flit after the handshake until the next load. selfDest follows dataOutL.
- Reset at any point, including mid-handshake:
  - FSM to IDLE; FIFO emptied (pointers and count 0).
  - Inr_L=0, dataOutL=0, txDone=0, overflow=0, selfDest=0 immediately.
  - An unacknowledged flit is lost.

## Timing
- Reset values: cpuBusy=0, overflow=0, dataOutL=37'b0, Inr_L=0, txDone=0, selfDest=0.
- Write at edge E0 into an empty FIFO with FSM in IDLE:
  - count=1 after E0.
  - At E1 the flit is popped; Inr_L=1 and dataOutL valid after E1.
  - Write-to-request latency is 1 cycle.
- An acknowledge sampled high at edge Ek gives Inr_L=0 and txDone=1 after Ek; txDone returns to 0 after Ek+1.
- Best-case throughput (router acknowledges in the first REQ cycle and releases immediately) is one flit per 3 cycles: IDLE, REQ, RELEASE.
- Inw_L=1 while in IDLE is ignored. An early acknowledge still held high on entry to RELEASE stalls the FSM until it falls.
- Ordering is strict FIFO; no flit is duplicated or reordered.

## Test plan
- Reset, then no activity:
  - All outputs stay at their reset values for 10 cycles.
  - Inw_L toggling in IDLE produces no Inr_L and no txDone.
- Single flit: write cpuData=32'hDEADBEEF, cpuDest=4'b1010.
  - Next cycle Inr_L=1 and dataOutL=37'h1BD5B7DDFA ({DEADBEEF,1,1010}), selfDest=0.
  - Acknowledge after 3 cycles gives one txDone pulse and Inr_L=0.
  - Inw_L released, FSM back in IDLE.
- Fill and overflow with the router stalled (Inw_L=0):
  - Write 5 words 1..5: the first is popped to REQ, 4 are buffered, cpuBusy=1.
  - A 6th write is dropped and overflow=1.
  - After releasing the router, flits arrive in order 1,2,3,4,5; overflow stays 1.
- Back-to-back writes while the router acknowledges every cycle:
  - Writes are accepted every cycle until cpuBusy=1 (full).
  - Flits leave at one per 3 cycles, in order.
- Self destination: cpuDest=4'b0101 gives selfDest=1 and the flit is still transmitted with bit4=1.
- Reset mid-handshake: assert reset while in REQ with 2 entries queued.
  - Inr_L falls asynchronously; the FIFO is empty afterwards.
  - After reset no flit is sent until a new write.
